regfile_mp: RTL

Parametrised multi-read-port register file for the MIPS datapath, the next generation of the single-cycle 2-read/1-write file. It is clocked rather than latch-based. It adds a configurable read-port count, a hard-wired zero register, link-register write steering for JAL, debug taps, and a multi-cycle background clear engine with a busy handshake. It sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clr_fsm.sv | 57 +++++
 rtl/regfile_mp.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its clear engine.
// Latency and backpressure: none (declarations only).
package regfile_pkg;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   localparam int REG_ZERO         = 0;
   localparam int DEF_NUM_REGS     = 32;
   localparam int DEF_LINK_REG     = DEF_NUM_REGS - 1;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Background clear engine: sweeps registers 1..NUM_REGS-1, one per cycle, after clr_req.
// Busy rises the cycle after clr_req is sampled for NUM_REGS-1 cycles; clr_req ignored while busy.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLR_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Register 0 is hard-wired, so the sweep starts at 1 and wraps idx back to 0 on exit.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_RUN;
               idx_d   = ADDR_W'(1);
            end
         end
         CLR_RUN: begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = CLR_IDLE;
            end
         end
         default: begin
            state_d = CLR_IDLE;
         end
      endcase
   end

   assign clr_busy = (state_q == CLR_RUN);
   assign clr_we   = (state_q == CLR_RUN);
   assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Clocked register file, NUM_RD combinational read ports, one write port, zero reg, link steering, debug taps.
// Write latency 1, read latency 0; writes during a background clear are dropped (wr_drop). Option: REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int LINK_REG = NUM_REGS - 1,
   parameter int NUM_TAP  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD*DATA_W-1:0]  rd_data,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      is_link,
   input  logic                      clr_req,
   output logic                      clr_busy,
   output logic                      wr_drop,
   output logic [NUM_TAP*DATA_W-1:0] tap_data
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_drop_q, wr_drop_d;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] wr_addr_eff;
   logic              wr_nonzero;
   logic              wr_commit;

   regfile_clr_fsm #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clr_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   assign wr_addr_eff = is_link ? ADDR_W'(LINK_REG) : wr_addr;
   assign wr_nonzero  = (wr_addr_eff != ADDR_W'(REG_ZERO));
   assign wr_commit   = wr_en && !clr_busy && wr_nonzero;
   // Register-0 writes are silent even during a clear; only real losses are flagged.
   assign wr_drop_d   = wr_en && clr_busy && wr_nonzero;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= wr_drop_d;
         if (clr_we) begin
            regs_q[clr_idx] <= '0;
         end
         if (wr_commit) begin
            regs_q[wr_addr_eff] <= wr_data;
         end
      end
   end

   assign wr_drop = wr_drop_q;

   // Entry 0 is reset to zero and never written, so a plain index returns 0 for address 0.
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = regs_q[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         if (wr_commit && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr_eff)) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data;
         end
`endif
      end
   end

   always_comb begin
      tap_data = '0;
      for (int t = 0; t < NUM_TAP; t++) begin
         tap_data[t*DATA_W +: DATA_W] = regs_q[t+1];
      end
   end

endmodule
